// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the IFU/LSU RAM arbiter.
package ram_arb_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } ram_arb_state_e;

  // Requester index / owner encoding; also the grant bit positions.
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Request/response channels of both requesters plus the RAMCtrl port.
interface ram_arbiter_if #(parameter int XLEN = ram_arb_pkg::XLEN);

  logic            ifu_req_valid;
  logic            ifu_req_ready;
  logic [XLEN-1:0] ifu_req_addr;
  logic            ifu_resp_valid;
  logic            ifu_resp_ready;
  logic [XLEN-1:0] ifu_resp_data;

  logic            lsu_req_valid;
  logic            lsu_req_ready;
  logic [XLEN-1:0] lsu_req_addr;
  logic            lsu_req_wen;
  logic [XLEN-1:0] lsu_req_wdata;
  logic [XLEN-1:0] lsu_req_wmask;
  logic            lsu_resp_valid;
  logic            lsu_resp_ready;
  logic [XLEN-1:0] lsu_resp_data;

  logic [XLEN-1:0] ram_raddr;
  logic [XLEN-1:0] ram_waddr;
  logic [XLEN-1:0] ram_wdata;
  logic [XLEN-1:0] ram_wmask;
  logic            ram_wen;
  logic [XLEN-1:0] ram_rdata;

  // Arbiter side.
  modport slave (
    input  ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
    input  lsu_resp_ready, ram_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    output ram_raddr, ram_waddr, ram_wdata, ram_wmask, ram_wen
  );

  // Requester/memory side.
  modport master (
    output ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
    output lsu_resp_ready, ram_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    input  ram_raddr, ram_waddr, ram_wdata, ram_wmask, ram_wen
  );

endinterface

// File: rtl/ram_rr_arb2.sv
// Two-input round-robin arbiter: one-hot grant, 1-bit priority pointer.
module ram_rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_q;

  // A lone requester always wins; on a tie the pointer's side wins.
  assign grant[0] = req[0] & (~req[1] | (ptr_q == OWN_IFU));
  assign grant[1] = req[1] & (~req[0] | (ptr_q == OWN_LSU));

  // Pointer moves to the side that did not just win.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       ptr_q <= OWN_LSU;
    else if (advance) ptr_q <= grant[0] ? OWN_LSU : OWN_IFU;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between IFU (read) and LSU (read/write),
// one transaction at a time: IDLE accept -> ISSUE -> WAIT -> RESP.
module ram_arbiter #(
  parameter int XLEN = ram_arb_pkg::XLEN
) (
  input  logic          clock,
  input  logic          reset,
  ram_arbiter_if.slave  bus
);
  import ram_arb_pkg::*;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic            wen;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] wmask;
  } ram_req_t;

  ram_arb_state_e  state_q, state_d;
  ram_req_t        req_q;
  logic            owner_q;
  logic [XLEN-1:0] resp_q;

  logic [1:0]      req_vld, grant;
  logic            ifu_rdy, lsu_rdy, accept, resp_hs;
  logic            ifu_rv, lsu_rv, wen;

  assign req_vld = {bus.lsu_req_valid, bus.ifu_req_valid};

  ram_rr_arb2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (req_vld),
    .advance (accept),
    .grant   (grant)
  );

  // Readies only in IDLE and never while reset is held.
  assign ifu_rdy = reset & (state_q == IDLE) & grant[OWN_IFU];
  assign lsu_rdy = reset & (state_q == IDLE) & grant[OWN_LSU];
  assign accept  = ifu_rdy | lsu_rdy;
  assign resp_hs = (owner_q == OWN_LSU) ? bus.lsu_resp_ready : bus.ifu_resp_ready;

  // State register; reset drops back to IDLE and discards any transaction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    ifu_rv  = 1'b0;
    lsu_rv  = 1'b0;
    wen     = 1'b0;
    case (state_q)
      IDLE:  if (accept) state_d = ISSUE;
      ISSUE: begin
        wen     = req_q.wen;
        state_d = WAIT;
      end
      WAIT:  state_d = RESP;
      RESP: begin
        ifu_rv = (owner_q == OWN_IFU);
        lsu_rv = (owner_q == OWN_LSU);
        if (resp_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the winner's request on the accept handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_q   <= '0;
      owner_q <= OWN_IFU;
    end else if (accept) begin
      owner_q <= lsu_rdy ? OWN_LSU : OWN_IFU;
      if (lsu_rdy) req_q <= '{bus.lsu_req_addr, bus.lsu_req_wen, bus.lsu_req_wdata, bus.lsu_req_wmask};
      else         req_q <= '{bus.ifu_req_addr, 1'b0, '0, '0};
    end
  end

  // Read data is valid in WAIT; writes answer with zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                resp_q <= '0;
    else if (state_q == WAIT)  resp_q <= req_q.wen ? '0 : bus.ram_rdata;
  end

  assign bus.ifu_req_ready  = ifu_rdy;
  assign bus.lsu_req_ready  = lsu_rdy;
  assign bus.ifu_resp_valid = ifu_rv;
  assign bus.lsu_resp_valid = lsu_rv;
  assign bus.ifu_resp_data  = (owner_q == OWN_IFU) ? resp_q : '0;
  assign bus.lsu_resp_data  = (owner_q == OWN_LSU) ? resp_q : '0;

  // RAM address/data come straight from the latched request, so they hold
  // between transactions; the write strobe is decoded from ISSUE only.
  assign bus.ram_raddr = req_q.addr;
  assign bus.ram_waddr = req_q.addr;
  assign bus.ram_wdata = req_q.wdata;
  assign bus.ram_wmask = req_q.wmask;
  assign bus.ram_wen   = wen;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small word-addressed RAM model.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  logic clock, reset;
  int   checks = 0;
  int   errors = 0;

  ram_arbiter_if #(.XLEN(XLEN)) bus();

  ram_arbiter #(.XLEN(XLEN)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model: masked write and registered read on the rising edge,
  // plus a backdoor port for preloading.
  logic [63:0] mem [0:31];
  logic        bd_en;
  logic [4:0]  bd_idx;
  logic [63:0] bd_data;

  always @(posedge clock) begin
    if (bd_en) mem[bd_idx] <= bd_data;
    else begin
      if (bus.ram_wen)
        mem[bus.ram_waddr[7:3]] <= (mem[bus.ram_waddr[7:3]] & ~bus.ram_wmask) |
                                   (bus.ram_wdata & bus.ram_wmask);
      bus.ram_rdata <= mem[bus.ram_raddr[7:3]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset              = 1'b0;
    bd_en              = 1'b0;
    bd_idx             = '0;
    bd_data            = '0;
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_req_addr   = '0;
    bus.ifu_resp_ready = 1'b1;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_req_addr   = '0;
    bus.lsu_req_wen    = 1'b0;
    bus.lsu_req_wdata  = '0;
    bus.lsu_req_wmask  = '0;
    bus.lsu_resp_ready = 1'b1;

    // Preload 0x8000_0000, 0x8000_0010, 0x8000_0020.
    cyc(); bd_en = 1'b1; bd_idx = 5'd0; bd_data = 64'h1122334455667788;
    cyc(); bd_idx = 5'd2; bd_data = 64'h0;
    cyc(); bd_idx = 5'd4; bd_data = 64'h5555;
    cyc(); bd_en = 1'b0;

    // Reset state with requests pending.
    bus.ifu_req_valid = 1'b1; bus.lsu_req_valid = 1'b1; #1;
    chk("rst_ifu_ready", bus.ifu_req_ready, 0);
    chk("rst_lsu_ready", bus.lsu_req_ready, 0);
    chk("rst_ifu_rv",    bus.ifu_resp_valid, 0);
    chk("rst_lsu_rv",    bus.lsu_resp_valid, 0);
    chk("rst_wen",       bus.ram_wen, 0);
    chk("rst_raddr",     bus.ram_raddr, 0);
    chk("rst_ifu_data",  bus.ifu_resp_data, 0);
    bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
    cyc(); reset = 1'b1;

    // IFU read alone.
    cyc();
    bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 64'h8000_0000; #1;
    chk("t1_ifu_ready", bus.ifu_req_ready, 1);
    chk("t1_lsu_ready", bus.lsu_req_ready, 0);
    cyc(); bus.ifu_req_valid = 1'b0;
    chk("t1_raddr",     bus.ram_raddr, 64'h8000_0000);
    chk("t1_wen",       bus.ram_wen, 0);
    chk("t1_busy_rdy",  bus.ifu_req_ready, 0);
    cyc(); chk("t1_rv_wait", bus.ifu_resp_valid, 0);
    cyc(); chk("t1_rv",   bus.ifu_resp_valid, 1);
    chk("t1_data", bus.ifu_resp_data, 64'h1122334455667788);
    cyc(); chk("t1_rv_done", bus.ifu_resp_valid, 0);

    // LSU write then IFU read-back.
    bus.lsu_req_valid = 1'b1; bus.lsu_req_wen = 1'b1; bus.lsu_req_addr = 64'h8000_0010;
    bus.lsu_req_wdata = 64'hDEADBEEF; bus.lsu_req_wmask = 64'h0000_0000_FFFF_FFFF; #1;
    chk("t2_lsu_ready", bus.lsu_req_ready, 1);
    cyc(); bus.lsu_req_valid = 1'b0;
    chk("t2_wen",   bus.ram_wen, 1);
    chk("t2_waddr", bus.ram_waddr, 64'h8000_0010);
    chk("t2_wdata", bus.ram_wdata, 64'hDEADBEEF);
    chk("t2_wmask", bus.ram_wmask, 64'h0000_0000_FFFF_FFFF);
    cyc(); chk("t2_wen_off", bus.ram_wen, 0);
    cyc(); chk("t2_rv", bus.lsu_resp_valid, 1);
    chk("t2_data", bus.lsu_resp_data, 0);
    cyc();
    bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 64'h8000_0010;
    cyc(); bus.ifu_req_valid = 1'b0;
    cyc(); cyc();
    chk("t2_readback", bus.ifu_resp_data, 64'h0000_0000_DEADBEEF);
    cyc();

    // Backpressure on LSU read while IFU waits; tie goes to LSU.
    bus.lsu_req_valid = 1'b1; bus.lsu_req_wen = 1'b0; bus.lsu_req_addr = 64'h8000_0000;
    bus.lsu_resp_ready = 1'b0;
    bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 64'h8000_0010; #1;
    chk("t4_tie_lsu", bus.lsu_req_ready, 1);
    chk("t4_tie_ifu", bus.ifu_req_ready, 0);
    cyc(); bus.lsu_req_valid = 1'b0;
    cyc(); cyc();
    for (int i = 0; i < 5; i++) begin
      chk("t4_bp_rv",      bus.lsu_resp_valid, 1);
      chk("t4_bp_data",    bus.lsu_resp_data, 64'h1122334455667788);
      chk("t4_bp_ifu_rdy", bus.ifu_req_ready, 0);
      chk("t4_bp_lsu_rdy", bus.lsu_req_ready, 0);
      chk("t4_bp_wen",     bus.ram_wen, 0);
      cyc();
    end
    chk("t4_bp_rv_end", bus.lsu_resp_valid, 1);
    bus.lsu_resp_ready = 1'b1;
    cyc(); chk("t4_waiter_rdy", bus.ifu_req_ready, 1);
    cyc(); bus.ifu_req_valid = 1'b0;
    cyc(); cyc();
    chk("t4_waiter_data", bus.ifu_resp_data, 64'h0000_0000_DEADBEEF);
    cyc();

    // Contention from reset: LSU, IFU, LSU, IFU every 4 cycles.
    reset = 1'b0;
    bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 64'h8000_0000;
    bus.lsu_req_valid = 1'b1; bus.lsu_req_wen = 1'b0; bus.lsu_req_addr = 64'h8000_0010;
    cyc(); reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic el;
      el = (k % 2 == 0);
      #1;
      chk("t3_lsu_rdy", bus.lsu_req_ready, el);
      chk("t3_ifu_rdy", bus.ifu_req_ready, !el);
      cyc(); cyc(); cyc();
      chk("t3_lsu_rv", bus.lsu_resp_valid, el);
      chk("t3_ifu_rv", bus.ifu_resp_valid, !el);
      if (el) chk("t3_lsu_data", bus.lsu_resp_data, 64'h0000_0000_DEADBEEF);
      else    chk("t3_ifu_data", bus.ifu_resp_data, 64'h1122334455667788);
      cyc();
    end
    bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;

    // Reset during WAIT of an IFU read.
    bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 64'h8000_0000; #1;
    chk("t5_lone_ifu", bus.ifu_req_ready, 1);
    cyc(); bus.ifu_req_valid = 1'b0;
    cyc(); reset = 1'b0; #1;
    chk("t5_rv",    bus.ifu_resp_valid, 0);
    chk("t5_raddr", bus.ram_raddr, 0);
    chk("t5_data",  bus.ifu_resp_data, 0);
    chk("t5_wen",   bus.ram_wen, 0);
    cyc(); cyc(); reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; chk("t5_no_resp", bus.ifu_resp_valid, 0);
      cyc();
    end
    bus.lsu_req_valid = 1'b1; bus.lsu_req_wen = 1'b0; bus.lsu_req_addr = 64'h8000_0000; #1;
    chk("t5_first_rdy", bus.lsu_req_ready, 1);
    cyc(); bus.lsu_req_valid = 1'b0;
    cyc(); cyc();
    chk("t5_after_rv",   bus.lsu_resp_valid, 1);
    chk("t5_after_data", bus.lsu_resp_data, 64'h1122334455667788);
    cyc();

    // Reset during ISSUE of a write: write must not land.
    bus.lsu_req_valid = 1'b1; bus.lsu_req_wen = 1'b1; bus.lsu_req_addr = 64'h8000_0020;
    bus.lsu_req_wdata = 64'hAAAA; bus.lsu_req_wmask = '1; #1;
    chk("t6_rdy", bus.lsu_req_ready, 1);
    cyc();
    chk("t6_wen_on", bus.ram_wen, 1);
    bus.lsu_req_valid = 1'b0; reset = 1'b0; #1;
    chk("t6_wen_drop", bus.ram_wen, 0);
    chk("t6_waddr",    bus.ram_waddr, 0);
    cyc(); reset = 1'b1;
    cyc();
    bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 64'h8000_0020;
    cyc(); bus.ifu_req_valid = 1'b0;
    cyc(); cyc();
    chk("t6_rv",   bus.ifu_resp_valid, 1);
    chk("t6_old",  bus.ifu_resp_data, 64'h5555);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
